arbitro_memoria: RTL and testbench

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

---
 rtl/arbitro_memoria_if.sv | 50 +++++
 rtl/arbitro_memoria.sv | 189 ++++++++++++++++++
 tb/tb_arbitro_memoria.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_memoria_if.sv
// Purpose: bundle between two memory requesters, the arbiter and a single-port memory.
// Latency: wires only, no storage in the bundle.
// Backpressure: a requester holds reqN and its operands until it samples ackN high.
interface arbitro_memoria_if #(
    parameter int BITS = 64
) ();
    // Requester 0
    logic            req0;
    logic            we0;
    logic [4:0]      addr0;
    logic [BITS-1:0] wdata0;
    logic            gnt0;
    logic            ack0;
    logic [BITS-1:0] rdata0;

    // Requester 1
    logic            req1;
    logic            we1;
    logic [4:0]      addr1;
    logic [BITS-1:0] wdata1;
    logic            gnt1;
    logic            ack1;
    logic [BITS-1:0] rdata1;

    // Memory port (combinational read data)
    logic [4:0]      mem_addr;
    logic            mem_We;
    logic [BITS-1:0] mem_din;
    logic [BITS-1:0] mem_dout;

    // Arbiter side: consumes requests and memory read data, drives grants and the memory port
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_dout,
        output gnt0, ack0, rdata0,
        output gnt1, ack1, rdata1,
        output mem_addr, mem_We, mem_din
    );

    // Environment side: requesters plus the memory itself
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_dout,
        input  gnt0, ack0, rdata0,
        input  gnt1, ack1, rdata1,
        input  mem_addr, mem_We, mem_din
    );
endinterface

// File: rtl/arbitro_memoria.sv
// Purpose: two-requester arbiter in front of a single-port memory; ARBITRO_RR_EN selects round-robin, else req0 has fixed priority.
// Latency: request sampled at edge E, memory access in the cycle after E, ackN in the cycle after E+1; one transaction per 3 cycles.
// Backpressure: requests are only sampled in IDLE; a held request simply waits through ACCESS/DONE and is never dropped.
module arbitro_memoria #(
    parameter int BITS  = 64,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    arbitro_memoria_if.slave bus
);
    localparam int ADDR_W = 5;

    // The address field is a fixed 5 bits, so the memory cannot be deeper than 32 words.
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_chk
        $error("arbitro_memoria: DEPTH must be within 1..32");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic              owner_q,  owner_d;   // requester that owns the current transaction
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [BITS-1:0]   wdata_q,  wdata_d;
    logic              gnt0_q,   gnt0_d;
    logic              gnt1_q,   gnt1_d;
    logic              ack0_q,   ack0_d;
    logic              ack1_q,   ack1_d;
    logic [BITS-1:0]   rdata0_q, rdata0_d;
    logic [BITS-1:0]   rdata1_q, rdata1_d;

    logic              any_req;
    logic              winner;              // 0 = requester 0, 1 = requester 1

`ifdef ARBITRO_RR_EN
    logic              last_q,   last_d;    // requester granted most recently
`endif

    assign any_req = bus.req0 | bus.req1;

`ifdef ARBITRO_RR_EN
    // Round-robin pick: a lone requester wins, on a tie the one not granted last wins
    always_comb begin
        winner = ~bus.req0;
        if (bus.req0 && bus.req1) begin
            winner = ~last_q;
        end
    end
`else
    // Fixed priority pick: requester 0 wins whenever it is requesting
    always_comb begin
        winner = ~bus.req0;
    end
`endif

    // Next-state, operand latching, grant/ack and read-data capture
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef ARBITRO_RR_EN
        last_d   = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    // Operands are frozen here; later input changes cannot disturb the access.
                    state_d = ST_ACCESS;
                    owner_d = winner;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                    if (winner) begin
                        we_d    = bus.we1;
                        addr_d  = bus.addr1;
                        wdata_d = bus.wdata1;
                    end else begin
                        we_d    = bus.we0;
                        addr_d  = bus.addr0;
                        wdata_d = bus.wdata0;
                    end
`ifdef ARBITRO_RR_EN
                    last_d  = winner;
`endif
                end
            end

            ST_ACCESS: begin
                // Memory read data is combinational, so it is valid at the end of ACCESS.
                state_d = ST_DONE;
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                if (!we_q) begin
                    if (owner_q) begin
                        rdata1_d = bus.mem_dout;
                    end else begin
                        rdata0_d = bus.mem_dout;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

`ifdef ARBITRO_RR_EN
    // Last-grant pointer; starts at 1 so requester 0 wins the first tie after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Memory port is driven only during ACCESS; decoding from the state register lets
    // an asynchronous reset drop mem_We before the next edge.
    always_comb begin
        bus.mem_We   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        if (state_q == ST_ACCESS) begin
            bus.mem_We   = we_q;
            bus.mem_addr = addr_q;
            bus.mem_din  = wdata_q;
        end
    end

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Purpose: self-checking bench for arbitro_memoria against a transaction-level model.
// Latency: each served request is checked at fixed offsets (ACCESS, DONE, IDLE) from its sampling edge.
// Backpressure: bench requesters hold their request until the ack cycle, losers stay held.
module tb_arbitro_memoria;
    localparam int BITS  = 64;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic preload;

    arbitro_memoria_if #(.BITS(BITS)) bus ();

    arbitro_memoria #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational read, synchronous write, survives DUT reset
    logic [BITS-1:0] env_mem [DEPTH];

    function automatic logic [BITS-1:0] init_word(input int i);
        case (i)
            0:       return 64'd51;
            2:       return 64'd94;
            5:       return 64'd18;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_word(i);
        end else if (bus.mem_We) begin
            env_mem[bus.mem_addr] <= bus.mem_din;
        end
    end

    assign bus.mem_dout = env_mem[bus.mem_addr];

    // Reference model state
    int              n_checks = 0;
    int              n_errors = 0;
    logic [BITS-1:0] ref_mem [DEPTH];
    bit              p      [2];
    bit              m_we   [2];
    logic [4:0]      m_addr [2];
    logic [BITS-1:0] m_wd   [2];
    logic [BITS-1:0] exp_rd [2];
    int              last_gnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BITS-1:0] rnd_word();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic gnt_of(input int n);
        return (n == 0) ? bus.gnt0 : bus.gnt1;
    endfunction

    function automatic logic ack_of(input int n);
        return (n == 0) ? bus.ack0 : bus.ack1;
    endfunction

    task automatic drive_port(input int n, input bit r, input bit w, input logic [4:0] a,
                              input logic [BITS-1:0] d);
        if (n == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic post(input int n, input bit w, input logic [4:0] a, input logic [BITS-1:0] d);
        p[n] = 1'b1; m_we[n] = w; m_addr[n] = a; m_wd[n] = d;
        drive_port(n, 1'b1, w, a, d);
    endtask

    // Arbitration rule: a lone requester wins; on a tie RR favours the one not granted last
    function automatic int pick();
        if (p[0] && p[1]) begin
`ifdef ARBITRO_RR_EN
            return 1 - last_gnt;
`else
            return 0;
`endif
        end
        return p[0] ? 0 : 1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        p[0] = 1'b0; p[1] = 1'b0;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        chk("rst_gnt_ack_we", {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.mem_We}, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_din", bus.mem_din, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_rdata1", bus.rdata1, 0);
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_gnt = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction, entered at a negedge while the DUT is in IDLE with >=1 pending request.
    task automatic run_round(input bit late, input bit lw, input logic [4:0] la,
                             input logic [BITS-1:0] ld, input bit perturb);
        int w;
        int l;
        w = pick();
        l = 1 - w;
        @(posedge clk);
        @(negedge clk);
        chk("acc_gnt_win", gnt_of(w), 1);
        chk("acc_gnt_lose", gnt_of(l), 0);
        chk("acc_ack", {bus.ack0, bus.ack1}, 0);
        chk("acc_mem_we", bus.mem_We, m_we[w]);
        chk("acc_mem_addr", bus.mem_addr, m_addr[w]);
        chk("acc_mem_din", bus.mem_din, m_wd[w]);
        if (perturb) drive_port(w, 1'b1, ~m_we[w], ~m_addr[w], rnd_word());
        if (late && !p[l]) post(l, lw, la, ld);
        @(posedge clk);
        @(negedge clk);
        if (m_we[w]) ref_mem[m_addr[w]] = m_wd[w];
        else         exp_rd[w] = ref_mem[m_addr[w]];
        chk("done_ack_win", ack_of(w), 1);
        chk("done_ack_lose", ack_of(l), 0);
        chk("done_gnt_win", gnt_of(w), 1);
        chk("done_gnt_lose", gnt_of(l), 0);
        chk("done_mem_we", bus.mem_We, 0);
        chk("rdata0", bus.rdata0, exp_rd[0]);
        chk("rdata1", bus.rdata1, exp_rd[1]);
        last_gnt = w;
        p[w] = 1'b0;
        drive_port(w, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        chk("idle_gnt_ack", {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1}, 0);
        chk("idle_mem_we", bus.mem_We, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preload = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        do_reset();
        preload = 1'b0;

        // Lone read by requester 1 of addr 5
        post(1, 1'b0, 5'd5, '0);
        run_round(1'b0, 1'b0, '0, '0, 1'b0);

        // Write by 0, then read-back by 1; operand changes during ACCESS are ignored
        post(0, 1'b1, 5'd3, 64'hAB);
        run_round(1'b0, 1'b0, '0, '0, 1'b1);
        post(1, 1'b0, 5'd3, '0);
        run_round(1'b0, 1'b0, '0, '0, 1'b0);

        // Both requesters held from reset; re-raise whichever was served
        do_reset();
        post(0, 1'b0, 5'd0, '0);
        post(1, 1'b0, 5'd2, '0);
        for (int k = 0; k < 4; k++) begin
            run_round(1'b0, 1'b0, '0, '0, 1'b0);
            post(last_gnt, 1'b0, (last_gnt == 0) ? 5'd0 : 5'd2, '0);
        end
        do_reset();

        // Requester 1 arrives during requester 0's ACCESS and is served next
        post(0, 1'b1, 5'd9, 64'h1234);
        run_round(1'b1, 1'b0, 5'd5, '0, 1'b0);
        run_round(1'b0, 1'b0, '0, '0, 1'b0);

        // Reset during a write's ACCESS aborts it
        post(0, 1'b1, 5'd7, 64'h55);
        @(posedge clk);
        #2;
        chk("abort_acc_we", bus.mem_We, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we", bus.mem_We, 0);
        chk("abort_outs", {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1}, 0);
        chk("abort_mem_addr", bus.mem_addr, 0);
        chk("abort_mem_din", bus.mem_din, 0);
        chk("abort_rdata", {bus.rdata0, bus.rdata1}, 0);
        p[0] = 1'b0;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        exp_rd[0] = '0; exp_rd[1] = '0;
        last_gnt = 1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_no_ack", {bus.ack0, bus.ack1, bus.gnt0, bus.gnt1}, 0);
        chk("abort_mem7", env_mem[7], ref_mem[7]);
        post(0, 1'b0, 5'd7, '0);
        run_round(1'b0, 1'b0, '0, '0, 1'b0);

        // Randomized traffic
        for (int r = 0; r < 60; r++) begin
            for (int n = 0; n < 2; n++) begin
                if (!p[n] && 1'($urandom_range(0, 1)))
                    post(n, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rnd_word());
            end
            if (!p[0] && !p[1])
                post(r % 2, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rnd_word());
            run_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), rnd_word(), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < DEPTH; i++) chk("mem_final", env_mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
